// File: rtl/alu_pkg.sv
// Shared ALU control codes, issue-controller states and defaults.
// Imported by the ALU, the issue controller and the testbench.
package alu_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_MUL = 3'b100
    } e_ALUControl;

    typedef enum logic {
        IDLE,
        MUL_WAIT
    } e_IssueState;

    // Codes 101/110/111 have no ALU operation behind them.
    function automatic logic is_illegal_op(input logic [2:0] op);
        return op > 3'b100;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_alu.sv
// Combinational execute-stage ALU: Add/Sub/And/Or/Mul, results truncated to DATA_W.
// Undefined control codes produce zero.
module alu_issue_ctrl_alu
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    input  logic [2:0]        ctrl_i,
    output logic [DATA_W-1:0] result_o
);

    always_comb begin
        // NOTE: default assignment first so no path leaves result_o unassigned (no latch).
        result_o = '0;
        case (ctrl_i)
            ALU_ADD: result_o = src_a_i + src_b_i;
            ALU_SUB: result_o = src_a_i - src_b_i;
            ALU_AND: result_o = src_a_i & src_b_i;
            ALU_OR:  result_o = src_a_i | src_b_i;
            ALU_MUL: result_o = src_a_i * src_b_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller owning the shared ALU: valid/ready in and out, Mul stalls.
// Optional performance counters are enabled with the ALU_ISSUE_PERF_EN macro.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MUL_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [4:0]        in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [4:0]        out_rd,
    output logic              out_illegal,
    output logic              busy
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_stall
`endif
);

    localparam int CNT_W = $clog2(MUL_LATENCY) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (MUL_LATENCY > 1) ? CNT_W'(MUL_LATENCY - 2) : '0;

    e_IssueState       state_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              out_valid_q, out_illegal_q;
    logic [DATA_W-1:0] out_result_q;
    logic [4:0]        out_rd_q;

    logic [DATA_W-1:0] alu_src_a, alu_src_b, alu_result;
    logic [2:0]        alu_ctrl;
    logic              out_free, accept, mul_multi, cap_now, cap_mul, capture;

    // Operands come straight from decode in IDLE and from the held copy while multiplying.
    assign alu_src_a = (state_q == MUL_WAIT) ? a_q  : in_a;
    assign alu_src_b = (state_q == MUL_WAIT) ? b_q  : in_b;
    assign alu_ctrl  = (state_q == MUL_WAIT) ? op_q : in_op;

    alu_issue_ctrl_alu #(.DATA_W(DATA_W)) u_alu (
        .src_a_i  (alu_src_a),
        .src_b_i  (alu_src_b),
        .ctrl_i   (alu_ctrl),
        .result_o (alu_result)
    );

    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = (state_q == IDLE) && out_free;
    assign accept    = in_valid && in_ready;
    assign mul_multi = (in_op == ALU_MUL) && (MUL_LATENCY > 1);
    assign cap_now   = accept && !mul_multi;
    assign cap_mul   = (state_q == MUL_WAIT) && (cnt_q == '0) && out_free;
    assign capture   = cap_now || cap_mul;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            // NOTE: held operands are reset too so a discarded Mul leaves no stale data behind.
            a_q           <= '0;
            b_q           <= '0;
            op_q          <= '0;
            rd_q          <= '0;
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            out_result_q  <= '0;
            out_rd_q      <= '0;
            out_illegal_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (capture) begin
                out_valid_q   <= 1'b1;
                out_result_q  <= alu_result;
                out_rd_q      <= cap_mul ? rd_q : in_rd;
                out_illegal_q <= cap_now && is_illegal_op(in_op);
            end else if (out_ready) begin
                out_valid_q   <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (accept && mul_multi) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        op_q    <= in_op;
                        rd_q    <= in_rd;
                        cnt_q   <= CNT_LOAD;
                        state_q <= MUL_WAIT;
                    end
                end
                MUL_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (out_free) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_rd      = out_rd_q;
    assign out_illegal = out_illegal_q;
    assign busy        = (state_q != IDLE);

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_ops_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (capture) perf_ops_q <= perf_ops_q + 32'd1;
            if (in_valid && !in_ready) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule
